// File: rtl/pkt_len_filter_pkg.sv
// Shared types and constants for the packet length filter.
// Holds the write FSM encoding, the ctrl "none" pattern and default limits.
package pkt_len_filter_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HDR,
        W_BODY,
        W_DROP
    } wr_state_e;

    // All-zero ctrl pattern; any other ctrl value marks a header or end word.
    localparam logic [63:0] CTRL_EOP_ANY = '0;

    localparam int DEF_MAX_PKT_WORDS = 200;
    localparam int WORD_CNT_W        = 9;

endpackage

// File: rtl/pkt_buf_ram.sv
// Simple dual-port packet buffer with one write port and a registered read port.
// The read register clears on reset so the output bus starts at zero.
module pkt_buf_ram #(
    parameter int WIDTH      = 72,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pkt_len_filter.sv
// Store-and-forward filter: releases whole packets of <= MAX_PKT_WORDS words.
// Define PKT_LEN_FILTER_STATS_EN to add saturating pass/drop packet counters.
module pkt_len_filter
    import pkt_len_filter_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int MAX_PKT_WORDS = DEF_MAX_PKT_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  drop_pulse
`ifdef PKT_LEN_FILTER_STATS_EN
    ,
    output logic [31:0]           pkt_pass_cnt,
    output logic [31:0]           pkt_drop_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int RW    = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [WORD_CNT_W-1:0] CNT_LIMIT = WORD_CNT_W'(MAX_PKT_WORDS + 1);

    if (MAX_PKT_WORDS > DEPTH - 2 || MAX_PKT_WORDS > 510) begin : g_bad_max
        $error("pkt_len_filter: MAX_PKT_WORDS must be <= DEPTH-2");
    end

    wr_state_e             state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  drop_body_q, drop_body_d;
    logic                  drop_pulse_q, drop_pulse_d;
    logic                  out_wr_q, out_wr_d;

    logic [PW-1:0]         used;
    logic [WORD_CNT_W-1:0] cnt_inc;
    logic                  ctl;
    logic                  full;
    logic                  accept;
    logic                  cnt_over;
    logic                  wr_en;
    logic                  rd_en;
    logic                  commit;

    assign used     = wr_ptr_q - rd_ptr_q;
    assign in_rdy   = used <= PW'(DEPTH - 2);
    assign full     = used == PW'(DEPTH);
    assign ctl      = in_ctrl != CTRL_WIDTH'(CTRL_EOP_ANY);
    assign accept   = in_wr && !full;
    assign cnt_inc  = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;
    assign cnt_over = cnt_inc == CNT_LIMIT;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        word_cnt_d   = word_cnt_q;
        drop_body_d  = drop_body_q;
        drop_pulse_d = 1'b0;
        wr_en        = 1'b0;
        commit       = 1'b0;
        if (accept) begin
            unique case (state_q)
                W_IDLE: begin
                    if (ctl) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        word_cnt_d = WORD_CNT_W'(1);
                        state_d    = W_HDR;
                    end
                end
                W_HDR, W_BODY: begin
                    if (cnt_over) begin
                        // Rewind to the last committed packet boundary.
                        wr_ptr_d     = commit_ptr_q;
                        drop_pulse_d = 1'b1;
                        if (state_q == W_BODY && ctl) begin
                            state_d = W_IDLE;
                        end else begin
                            state_d     = W_DROP;
                            drop_body_d = (state_q == W_BODY) || !ctl;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        word_cnt_d = cnt_inc;
                        if (state_q == W_HDR && !ctl) begin
                            state_d = W_BODY;
                        end else if (state_q == W_BODY && ctl) begin
                            commit       = 1'b1;
                            commit_ptr_d = wr_ptr_q + 1'b1;
                            state_d      = W_IDLE;
                        end
                    end
                end
                W_DROP: begin
                    if (ctl && drop_body_q) begin
                        state_d = W_IDLE;
                    end else if (!ctl) begin
                        drop_body_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only committed words are ever read.
    always_comb begin
        rd_en    = (rd_ptr_q != commit_ptr_q) && out_rdy;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_wr_d = rd_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= W_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            word_cnt_q   <= '0;
            drop_body_q  <= 1'b0;
            drop_pulse_q <= 1'b0;
            out_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            word_cnt_q   <= word_cnt_d;
            drop_body_q  <= drop_body_d;
            drop_pulse_q <= drop_pulse_d;
            out_wr_q     <= out_wr_d;
        end
    end

    pkt_buf_ram #(
        .WIDTH      (RW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data ({in_ctrl, in_data}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data ({out_ctrl, out_data})
    );

    assign out_wr     = out_wr_q;
    assign drop_pulse = drop_pulse_q;

`ifdef PKT_LEN_FILTER_STATS_EN
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (commit && pass_cnt_q != '1) begin
            pass_cnt_d = pass_cnt_q + 32'd1;
        end
        if (drop_pulse_d && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_pass_cnt = pass_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_len_filter.sv
// Randomized self-checking bench for pkt_len_filter.
// Expected output is the in-order stream of packets no longer than MAX words.
module tb_pkt_len_filter;

    localparam int MAX = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        drop_pulse;
`ifdef PKT_LEN_FILTER_STATS_EN
    logic [31:0] pkt_pass_cnt;
    logic [31:0] pkt_drop_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int drops_seen = 0;
    int exp_drops = 0;
    int st_pass = 0;
    int st_drop = 0;
    int outs_seen = 0;
    int first_out_cyc = -1;
    int t_end = 0;
    int words_driven = 0;
    int stall_words = -1;
    bit rand_rdy = 1'b0;
    bit rdy_force = 1'b1;
    logic rdy_seen = 1'b0;
    logic [71:0] exp_q[$];

    pkt_len_filter dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .drop_pulse (drop_pulse)
`ifdef PKT_LEN_FILTER_STATS_EN
        ,
        .pkt_pass_cnt (pkt_pass_cnt),
        .pkt_drop_cnt (pkt_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rdy_seen <= in_rdy;
    end

    always @(negedge clk) begin
        out_rdy <= rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (drop_pulse) drops_seen++;
            if (out_wr) begin
                outs_seen++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {out_ctrl, out_data}, 72'hx);
                end else begin
                    chk("out_word", {out_ctrl, out_data}, exp_q.pop_front());
                end
            end
        end
    end

    // Upstream honours in_rdy one cycle late, so it may send one extra word.
    task automatic drive(input logic [7:0] c, input logic [63:0] d);
        int budget = 5000;
        while (!rdy_seen && budget > 0) begin
            if (stall_words < 0) stall_words = words_driven;
            in_wr = 1'b0;
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("in_rdy_timeout", 0, 1);
        in_wr = 1'b1;
        in_ctrl = c;
        in_data = d;
        t_end = cyc;
        words_driven++;
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int nhdr);
        bit keep = (len <= MAX);
        for (int i = 0; i < len; i++) begin
            logic [7:0]  c;
            logic [63:0] d;
            d = {$urandom, $urandom};
            if (i == 0) c = 8'hFF;
            else if (i < nhdr) c = 8'($urandom_range(1, 255));
            else if (i == len - 1) c = 8'($urandom_range(1, 255));
            else c = 8'h00;
            if (keep) exp_q.push_back({c, d});
            drive(c, d);
        end
        if (keep) st_pass++;
        else begin
            exp_drops++;
            st_drop++;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(tag, exp_q.size(), 0);
        chk({tag, "_drops"}, drops_seen, exp_drops);
`ifdef PKT_LEN_FILTER_STATS_EN
        chk({tag, "_pass_cnt"}, pkt_pass_cnt, st_pass);
        chk({tag, "_drop_cnt"}, pkt_drop_cnt, st_drop);
`endif
    endtask

    initial begin
        int base;
        #2;
        chk("rst_out_wr", out_wr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_drop", drop_pulse, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_out_wr_rel", out_wr, 0);

        // Single 10-word packet and its first-word latency.
        first_out_cyc = -1;
        base = outs_seen;
        send_pkt(10, 1);
        wait_drain("t1_drain");
        chk("t1_latency", first_out_cyc - t_end, 2);
        chk("t1_count", outs_seen - base, 10);

        // 201 words ending on overflow, then a short packet.
        send_pkt(201, 1);
        send_pkt(5, 2);
        wait_drain("t2_drain");

        // Exactly MAX, end-on-overflow, back-to-back, then mid-body drop.
        base = outs_seen;
        send_pkt(200, 1);
        send_pkt(201, 3);
        send_pkt(5, 1);
        send_pkt(250, 1);
        send_pkt(4, 1);
        wait_drain("t3_drain");
        chk("t3_count", outs_seen - base, 209);

        // Stray body words while idle.
        base = outs_seen;
        for (int i = 0; i < 3; i++) drive(8'h00, {$urandom, $urandom});
        send_pkt(7, 1);
        wait_drain("t4_drain");
        chk("t4_count", outs_seen - base, 7);

        // Fill the buffer with out_rdy low, then release.
        rdy_force = 1'b0;
        repeat (3) @(negedge clk);
        base = outs_seen;
        words_driven = 0;
        stall_words = -1;
        fork
            begin
                for (int p = 0; p < 5; p++) send_pkt(60, 1);
            end
            begin
                int n = 0;
                while (stall_words < 0 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                chk("t5_stall_seen", stall_words >= 0, 1);
                chk("t5_stall_words", stall_words, 256);
                chk("t5_in_rdy_low", in_rdy, 0);
                chk("t5_no_out", outs_seen - base, 0);
                rdy_force = 1'b1;
            end
        join
        wait_drain("t5_drain");
        chk("t5_count", outs_seen - base, 300);

        // Random lengths, headers, strays and output backpressure.
        rand_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int nh = $urandom_range(1, 3);
            int ln = $urandom_range(nh + 2, 260);
            int ns = $urandom_range(0, 2);
            for (int s = 0; s < ns; s++) drive(8'h00, {$urandom, $urandom});
            send_pkt(ln, nh);
        end
        wait_drain("t6_drain");
        rand_rdy = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset while a packet is arriving and another drains.
        send_pkt(50, 1);
        for (int i = 0; i < 5; i++) begin
            drive((i == 0) ? 8'hFF : 8'h00, {$urandom, $urandom});
        end
        chk("t7_pre_out_wr", out_wr, 1);
        #3;
        reset = 1'b1;
        exp_q.delete();
        st_pass = 0;
        st_drop = 0;
        #1;
        chk("t7_rst_out_wr", out_wr, 0);
        chk("t7_rst_out_data", {out_ctrl, out_data}, 0);
        chk("t7_rst_drop", drop_pulse, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        base = outs_seen;
        send_pkt(4, 1);
        wait_drain("t7_drain");
        chk("t7_count", outs_seen - base, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
